// File: rtl/int_controller.sv
`timescale 1ns/1ps
// int_controller
// Vectored interrupt controller in front of the single-cycle MIPS core.
// Rising edges on irq_in are latched into a pending set. The lowest-index
// pending source that is also enabled in MASK is presented to the core as
// a request with a handler vector. The request is held until int_ack, and
// the controller then stays in service until eoi.
//
// Handshake: int_req is a level that stays high until the core answers with
// a one-cycle int_ack pulse, or until the latched source stops being eligible
// (software clear or mask). An ack sampled in the same cycle as a withdrawal
// wins. eoi is a one-cycle pulse that only has meaning while in service.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   irq_in[NUM_SRC]     peripheral lines, synchronous to clk, edge events
//   int_req / int_ack   request to the core / acknowledge pulse from it
//   eoi                 end-of-interrupt pulse at handler return
//   int_vector, int_id  handler address and index of the latched source
//   we, addr, wdata     register write port (addr = bus address [3:2])
//   rdata               combinational register read data
//   o_dbg_state         current FSM state (0 IDLE, 1 REQ, 2 SERVICE)
//
// Register map
//   0 MASK     r/w, 1 enables a source
//   1 PENDING  read; write-1-to-clear
//   2 STATUS   bit0 int_req, bit1 in_service, bits[6:4] int_id
//   3          reads 0
module int_controller #(
  parameter int          NUM_SRC     = 4,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               int_req,
  input  logic               int_ack,
  input  logic               eoi,
  output logic [31:0]        int_vector,
  output logic [2:0]         int_id,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_id;
  logic [2:0]         w_id_next;
  logic [NUM_SRC-1:0] r_irq_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_eligible;
  logic [7:0]         w_elig8;
  logic [NUM_SRC-1:0] w_id_onehot;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_sw_clr;
  logic               w_any;
  logic [2:0]         w_win_id;
  logic               w_in_service;
  logic               w_unused_wdata;

  assign w_rise     = irq_in & ~r_irq_prev;
  assign w_eligible = r_pending & r_mask;
  assign w_any      = |w_eligible;
  assign w_sw_clr   = (we && addr == 2'd1) ? wdata[NUM_SRC-1:0] : '0;
  assign w_unused_wdata = ^wdata;

  // Eligible set widened to 8 bits so the 3-bit id can index it for any
  // NUM_SRC; also a one-hot of the latched id for the ack clear.
  always_comb begin
    w_elig8     = '0;
    w_id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_elig8[i]     = w_eligible[i];
      w_id_onehot[i] = (r_id == 3'(i));
    end
  end

  // Fixed priority: scan from the top so the lowest eligible index wins.
  always_comb begin
    w_win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_win_id = 3'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_id_next    = r_id;
    w_ack_clr    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next = S_REQ;
          w_id_next    = w_win_id;
        end
      end
      S_REQ: begin
        // Ack takes precedence over withdrawal; id is never re-arbitrated here.
        if (int_ack) begin
          w_state_next = S_SERVICE;
          w_ack_clr    = w_id_onehot;
        end else if (!w_elig8[r_id]) begin
          w_state_next = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_id       <= '0;
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_id       <= w_id_next;
      r_irq_prev <= irq_in;
      // A new edge on a bit being cleared in the same cycle is kept.
      r_pending  <= (r_pending & ~(w_ack_clr | w_sw_clr)) | w_rise;
      if (we && addr == 2'd0) r_mask <= wdata[NUM_SRC-1:0];
    end
  end

  assign w_in_service = (r_state == S_SERVICE);
  assign int_req      = (r_state == S_REQ);
  assign int_id       = r_id;
  assign int_vector   = VECTOR_BASE + {25'd0, r_id, 4'd0};
  assign o_dbg_state  = r_state;

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = 32'(r_mask);
      2'd1:    rdata = 32'(r_pending);
      2'd2:    rdata = {25'd0, r_id, 2'b00, w_in_service, int_req};
      default: rdata = '0;
    endcase
  end

endmodule
